// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and sizes for the register write-back path.
// Decode and the register bank import this same package.
package reg_writeback_unit_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 3;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bus between the ALU/decode side (master) and the write-back unit (slave).
interface reg_writeback_unit_if;
   import reg_writeback_unit_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [SEL_W-1:0]  in_dest;
   logic              wr_hold;
   logic              wr_en;
   logic [SEL_W-1:0]  wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic [SEL_W-1:0]  srcreg1_sel;
   logic [SEL_W-1:0]  srcreg2_sel;
   logic              fwd1_hit;
   logic              fwd2_hit;
   logic [DATA_W-1:0] fwd1_data;
   logic [DATA_W-1:0] fwd2_data;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, in_data, in_dest, wr_hold, srcreg1_sel, srcreg2_sel,
      input  in_ready, wr_en, wr_sel, wr_data, fwd1_hit, fwd2_hit,
             fwd1_data, fwd2_data, count
   );

   modport slave (
      input  in_valid, in_data, in_dest, wr_hold, srcreg1_sel, srcreg2_sel,
      output in_ready, wr_en, wr_sel, wr_data, fwd1_hit, fwd2_hit,
             fwd1_data, fwd2_data, count
   );

endinterface

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Pending-write FIFO. Besides the head it exposes every slot in age order
// (index 0 = oldest) so the forwarding search needs no pointer arithmetic.
module wb_fifo
   import reg_writeback_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        push_entry,
   output wb_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output wb_entry_t        entries [DEPTH],
   output logic [DEPTH-1:0] entry_valid
);

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Push and pop are gated here, so count can never pass DEPTH or wrap below 0.
   assign full    = (count == FULL_COUNT);
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         entries[k]     = mem[rd_ptr + PTR_W'(k)];
         entry_valid[k] = (CNT_W'(k) < count);
      end
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-back unit: queues tagged ALU results, commits one per cycle to the
// bank write port and forwards the youngest pending value per source select.
module reg_writeback_unit
   import reg_writeback_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   reg_writeback_unit_if.slave  bus
);

   wb_entry_t         push_entry;
   wb_entry_t         head;
   wb_entry_t         entries [DEPTH];
   logic [DEPTH-1:0]  entry_valid;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              pop_fire;

   logic              out_en;
   logic [SEL_W-1:0]  out_sel;
   logic [DATA_W-1:0] out_data;

   logic              hit1;
   logic              hit2;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;

   assign push_entry = '{sel: bus.in_dest, data: bus.in_data};
   assign pop_fire   = !bus.wr_hold && (fifo_count != '0);

   wb_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (bus.in_valid),
      .pop         (pop_fire),
      .push_entry  (push_entry),
      .head        (head),
      .count       (fifo_count),
      .full        (fifo_full),
      .entries     (entries),
      .entry_valid (entry_valid)
   );

   // Output stage: sel/data keep their last committed values while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_en   <= 1'b0;
         out_sel  <= '0;
         out_data <= '0;
      end else if (pop_fire) begin
         out_en   <= 1'b1;
         out_sel  <= head.sel;
         out_data <= head.data;
      end else begin
         out_en   <= 1'b0;
      end
   end

   // Oldest candidate first so that each younger match overrides the previous one.
   always_comb begin
      hit1  = 1'b0;
      hit2  = 1'b0;
      data1 = '0;
      data2 = '0;
      if (out_en && (out_sel == bus.srcreg1_sel)) begin
         hit1  = 1'b1;
         data1 = out_data;
      end
      if (out_en && (out_sel == bus.srcreg2_sel)) begin
         hit2  = 1'b1;
         data2 = out_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (entry_valid[k] && (entries[k].sel == bus.srcreg1_sel)) begin
            hit1  = 1'b1;
            data1 = entries[k].data;
         end
         if (entry_valid[k] && (entries[k].sel == bus.srcreg2_sel)) begin
            hit2  = 1'b1;
            data2 = entries[k].data;
         end
      end
   end

   assign bus.in_ready  = !fifo_full;
   assign bus.count     = fifo_count;
   assign bus.wr_en     = out_en;
   assign bus.wr_sel    = out_sel;
   assign bus.wr_data   = out_data;
   assign bus.fwd1_hit  = hit1;
   assign bus.fwd2_hit  = hit2;
   assign bus.fwd1_data = data1;
   assign bus.fwd2_data = data2;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed scenario bench for reg_writeback_unit with hand-computed expectations.
module tb_reg_writeback_unit;
   import reg_writeback_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   reg_writeback_unit_if bus ();

   reg_writeback_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_dest     = '0;
      bus.wr_hold     = 1'b0;
      bus.srcreg1_sel = '0;
      bus.srcreg2_sel = '0;
      repeat (2) step();
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got %b want 0", bus.wr_en); end
      checks++; if (bus.wr_sel !== 3'd0) begin failures++; $display("[TB] FAIL reset_wr_sel got %0d want 0", bus.wr_sel); end
      checks++; if (bus.wr_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_wr_data got %h want 0000", bus.wr_data); end
      checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_fwd_hit got %b%b want 00", bus.fwd1_hit, bus.fwd2_hit); end
      checks++; if (bus.fwd1_data !== 16'h0000 || bus.fwd2_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_fwd_data got %h/%h want 0000/0000", bus.fwd1_data, bus.fwd2_data); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_push();
      bus.in_valid = 1'b1;
      bus.in_dest  = 3'd3;
      bus.in_data  = 16'h1234;
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.count !== 3'd1 || bus.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_queued got count=%0d wr_en=%b want count=1 wr_en=0", bus.count, bus.wr_en); end
      step();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 3'd3 || bus.wr_data !== 16'h1234) begin failures++; $display("[TB] FAIL single_commit got en=%b sel=%0d data=%h want en=1 sel=3 data=1234", bus.wr_en, bus.wr_sel, bus.wr_data); end
      checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL single_count got %0d want 0", bus.count); end
      step();
      checks++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 3'd3 || bus.wr_data !== 16'h1234) begin failures++; $display("[TB] FAIL single_idle got en=%b sel=%0d data=%h want en=0 sel=3 data=1234", bus.wr_en, bus.wr_sel, bus.wr_data); end
   endtask

   task automatic test_full_hold();
      logic [SEL_W-1:0]  dests [4];
      logic [DATA_W-1:0] datas [4];
      logic [DATA_W-1:0] fwd_exp [4];
      logic              hit_exp [4];
      dests   = '{3'd1, 3'd2, 3'd1, 3'd5};
      datas   = '{16'h0001, 16'h0002, 16'h00AA, 16'h0005};
      fwd_exp = '{16'h00AA, 16'h00AA, 16'h00AA, 16'h0000};
      hit_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
      bus.wr_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_ready_%0d got %b want 1", i, bus.in_ready); end
         bus.in_valid = 1'b1;
         bus.in_dest  = dests[i];
         bus.in_data  = datas[i];
         step();
      end
      checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL hold_full got count=%0d ready=%b want count=4 ready=0", bus.count, bus.in_ready); end
      bus.in_dest = 3'd7;
      bus.in_data = 16'h0BAD;
      repeat (2) step();
      checks++; if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL hold_fifth_rejected got count=%0d want 4", bus.count); end
      bus.srcreg1_sel = 3'd1;
      bus.srcreg2_sel = 3'd5;
      #1;
      checks++; if (bus.fwd1_hit !== 1'b1 || bus.fwd1_data !== 16'h00AA) begin failures++; $display("[TB] FAIL hold_fwd_r1 got hit=%b data=%h want hit=1 data=00aa", bus.fwd1_hit, bus.fwd1_data); end
      checks++; if (bus.fwd2_hit !== 1'b1 || bus.fwd2_data !== 16'h0005) begin failures++; $display("[TB] FAIL hold_fwd_r5 got hit=%b data=%h want hit=1 data=0005", bus.fwd2_hit, bus.fwd2_data); end
      bus.srcreg2_sel = 3'd7;
      #1;
      checks++; if (bus.fwd2_hit !== 1'b0 || bus.fwd2_data !== 16'h0000) begin failures++; $display("[TB] FAIL hold_fwd_r7 got hit=%b data=%h want hit=0 data=0000", bus.fwd2_hit, bus.fwd2_data); end
      bus.in_valid = 1'b0;
      bus.wr_hold  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== dests[i] || bus.wr_data !== datas[i]) begin failures++; $display("[TB] FAIL drain_%0d got en=%b sel=%0d data=%h want en=1 sel=%0d data=%h", i, bus.wr_en, bus.wr_sel, bus.wr_data, dests[i], datas[i]); end
         checks++; if (bus.count !== 3'(3 - i)) begin failures++; $display("[TB] FAIL drain_count_%0d got %0d want %0d", i, bus.count, 3 - i); end
         checks++; if (bus.fwd1_hit !== hit_exp[i] || bus.fwd1_data !== fwd_exp[i]) begin failures++; $display("[TB] FAIL drain_fwd_%0d got hit=%b data=%h want hit=%b data=%h", i, bus.fwd1_hit, bus.fwd1_data, hit_exp[i], fwd_exp[i]); end
      end
      step();
      checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("[TB] FAIL drain_done got en=%b count=%0d want en=0 count=0", bus.wr_en, bus.count); end
   endtask

   task automatic test_back_to_back();
      bus.wr_hold  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.in_dest = 3'(i);
         bus.in_data = 16'hC000 + 16'(i);
         step();
      end
      bus.wr_hold = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.in_dest = 3'(i + 2);
         bus.in_data = 16'hC002 + 16'(i);
         step();
         checks++; if (bus.count !== 3'd2) begin failures++; $display("[TB] FAIL b2b_count_%0d got %0d want 2", i, bus.count); end
         checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 3'(i) || bus.wr_data !== 16'hC000 + 16'(i)) begin failures++; $display("[TB] FAIL b2b_commit_%0d got en=%b sel=%0d data=%h want en=1 sel=%0d data=%h", i, bus.wr_en, bus.wr_sel, bus.wr_data, i % 8, 16'hC000 + 16'(i)); end
      end
      bus.in_valid = 1'b0;
      for (int i = 10; i < 12; i++) begin
         step();
         checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 3'(i) || bus.wr_data !== 16'hC000 + 16'(i)) begin failures++; $display("[TB] FAIL b2b_tail_%0d got en=%b sel=%0d data=%h want en=1 sel=%0d data=%h", i, bus.wr_en, bus.wr_sel, bus.wr_data, i % 8, 16'hC000 + 16'(i)); end
      end
      step();
      checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("[TB] FAIL b2b_done got en=%b count=%0d want en=0 count=0", bus.wr_en, bus.count); end
   endtask

   task automatic test_forward_single();
      bus.srcreg1_sel = 3'd6;
      bus.srcreg2_sel = 3'd3;
      #1;
      checks++; if (bus.fwd1_hit !== 1'b0 || bus.fwd1_data !== 16'h0000) begin failures++; $display("[TB] FAIL fwd_idle got hit=%b data=%h want hit=0 data=0000", bus.fwd1_hit, bus.fwd1_data); end
      bus.in_valid = 1'b1;
      bus.in_dest  = 3'd6;
      bus.in_data  = 16'hBEEF;
      #1;
      checks++; if (bus.fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd_same_cycle got hit=%b want 0", bus.fwd1_hit); end
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.fwd1_hit !== 1'b1 || bus.fwd1_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL fwd_queued got hit=%b data=%h want hit=1 data=beef", bus.fwd1_hit, bus.fwd1_data); end
      checks++; if (bus.fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd_other_src got hit=%b want 0", bus.fwd2_hit); end
      step();
      checks++; if (bus.wr_en !== 1'b1 || bus.fwd1_hit !== 1'b1 || bus.fwd1_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL fwd_out_stage got en=%b hit=%b data=%h want en=1 hit=1 data=beef", bus.wr_en, bus.fwd1_hit, bus.fwd1_data); end
      step();
      checks++; if (bus.fwd1_hit !== 1'b0 || bus.fwd1_data !== 16'h0000) begin failures++; $display("[TB] FAIL fwd_after_commit got hit=%b data=%h want hit=0 data=0000", bus.fwd1_hit, bus.fwd1_data); end
   endtask

   task automatic test_reset_midop();
      bus.wr_hold  = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_dest = 3'd4;
         bus.in_data = 16'h4400 + 16'(i);
         step();
      end
      bus.in_valid = 1'b0;
      bus.wr_hold  = 1'b0;
      step();
      bus.wr_hold     = 1'b1;
      bus.srcreg1_sel = 3'd4;
      #1;
      checks++; if (bus.wr_en !== 1'b1 || bus.count !== 3'd3 || bus.fwd1_hit !== 1'b1) begin failures++; $display("[TB] FAIL midop_pre got en=%b count=%0d hit=%b want en=1 count=3 hit=1", bus.wr_en, bus.count, bus.fwd1_hit); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0 || bus.fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL midop_async got en=%b count=%0d hit=%b want en=0 count=0 hit=0", bus.wr_en, bus.count, bus.fwd1_hit); end
      checks++; if (bus.in_ready !== 1'b1 || bus.wr_data !== 16'h0000) begin failures++; $display("[TB] FAIL midop_async_outs got ready=%b data=%h want ready=1 data=0000", bus.in_ready, bus.wr_data); end
      step();
      rst_n       = 1'b1;
      bus.wr_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("[TB] FAIL midop_stale_%0d got en=%b count=%0d want en=0 count=0", i, bus.wr_en, bus.count); end
      end
   endtask

   task automatic test_same_register();
      bus.in_valid = 1'b1;
      bus.in_dest  = 3'd2;
      bus.in_data  = 16'h7777;
      step();
      bus.in_valid    = 1'b0;
      bus.srcreg1_sel = 3'd2;
      bus.srcreg2_sel = 3'd2;
      #1;
      checks++; if (bus.fwd1_hit !== 1'b1 || bus.fwd1_data !== 16'h7777) begin failures++; $display("[TB] FAIL same_reg_fwd1 got hit=%b data=%h want hit=1 data=7777", bus.fwd1_hit, bus.fwd1_data); end
      checks++; if (bus.fwd2_hit !== 1'b1 || bus.fwd2_data !== 16'h7777) begin failures++; $display("[TB] FAIL same_reg_fwd2 got hit=%b data=%h want hit=1 data=7777", bus.fwd2_hit, bus.fwd2_data); end
      step();
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 3'd2 || bus.fwd2_data !== 16'h7777) begin failures++; $display("[TB] FAIL same_reg_commit got en=%b sel=%0d fwd2=%h want en=1 sel=2 fwd2=7777", bus.wr_en, bus.wr_sel, bus.fwd2_data); end
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single_push();
      test_full_hold();
      test_back_to_back();
      test_forward_single();
      test_reset_midop();
      test_same_register();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
